// File: rtl/bfp_block_norm.sv
// bfp_block_norm -- block-floating-point normaliser.
//
// Collects a block of N signed samples and tracks the smallest headroom
// (redundant sign bits) among the non-zero samples. It then streams the block
// back out, with every sample left-shifted by that one shared exponent. Fill
// and drain never overlap because the design has a single buffer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; discards any partial block
//   in_valid   input sample valid
//   in_ready   high while filling (FILL state)
//   in_data    signed W-bit input sample
//   out_valid  registered output valid
//   out_ready  downstream accepts the current output
//   out_data   buffered sample << out_exp
//   out_last   marks the N-th sample of the block
//   out_exp    shared shift for the block being drained
//   busy       high while draining (DRAIN state)
module bfp_block_norm #(
    parameter int W  = 24,
    parameter int N  = 16,
    parameter int EW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [EW-1:0] out_exp,
    output logic          busy
);

    localparam int CW = $clog2(N);
    localparam logic [EW-1:0] H_INIT   = EW'(W - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {FILL, DRAIN} state_e;

    // Headroom: the run length of bits below the MSB, starting at bit W-2,
    // that match the sign bit.
    function automatic logic [EW-1:0] headroom(input logic [W-1:0] x);
        logic [EW-1:0] h;
        logic          run;
        h   = '0;
        run = 1'b1;
        for (int i = W - 2; i >= 0; i--) begin
            if (run && (x[i] == x[W-1])) h = h + EW'(1);
            else                         run = 1'b0;
        end
        return h;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;       // write index in FILL, load index in DRAIN
    logic [EW-1:0] min_h_q, min_h_d;
    logic          any_nz_q, any_nz_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [EW-1:0] out_exp_q, out_exp_d;
    logic [W-1:0]  mem_q [N];

    logic          accept;
    logic          in_nz;
    logic [EW-1:0] in_h;

    assign accept = (state_q == FILL) && in_valid;
    assign in_nz  = |in_data;
    assign in_h   = headroom(in_data);

    always_comb begin
        // NOTE: every _d gets its hold value first, so a path that does not
        // assign a signal cannot infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        min_h_d     = min_h_q;
        any_nz_d    = any_nz_q;
        exp_d       = exp_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_exp_d   = out_exp_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    // A zero sample has no meaningful headroom, so it is skipped.
                    if (in_nz && (in_h < min_h_q)) min_h_d = in_h;
                    any_nz_d = any_nz_q | in_nz;
                    if (cnt_q == LAST_IDX) begin
                        exp_d   = any_nz_d ? min_h_d : '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The output register is either empty or being consumed.
                if (!out_valid_q || out_ready) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        min_h_d     = H_INIT;
                        any_nz_d    = 1'b0;
                        cnt_d       = '0;
                        state_d     = FILL;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = mem_q[cnt_q] << exp_q;
                        out_last_d  = (cnt_q == LAST_IDX);
                        out_exp_d   = exp_q;
                        cnt_d       = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            min_h_q     <= H_INIT;
            any_nz_q    <= 1'b0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            min_h_q     <= min_h_d;
            any_nz_q    <= any_nz_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_exp_q   <= out_exp_d;
        end
    end

    // NOTE: the sample buffer has no reset. Each entry is written before it
    // is read, and leaving out the reset lets the buffer map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) mem_q[cnt_q] <= in_data;
    end

    assign in_ready  = (state_q == FILL);
    assign busy      = (state_q == DRAIN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_exp   = out_exp_q;

endmodule

// File: tb/tb_bfp_block_norm.sv
// tb_bfp_block_norm -- self-checking bench for bfp_block_norm with W=24, N=4.
// It applies directed vectors from a table, reset corner cases, and random
// blocks under random output back-pressure. The reference model works out
// headroom from the signed range each value fits in.
module tb_bfp_block_norm;

    localparam int W  = 24;
    localparam int N  = 4;
    localparam int EW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [EW-1:0] out_exp;
    logic          busy;

    bfp_block_norm #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_exp   (out_exp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                 name;
        logic [N-1:0][W-1:0]   din;
        logic [N-1:0][W-1:0]   dout;
        int                    e;
    } vec_t;

    vec_t         vecs [4];
    logic [W-1:0] cur_in  [N];
    logic [W-1:0] exp_blk [N];
    int           exp_e;
    int           n_checks = 0;
    int           n_bad    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference headroom: the largest k such that the value fits in W-k signed bits.
    function automatic int ref_h(input logic [W-1:0] x);
        longint v;
        longint lim;
        v = longint'(x);
        if (x[W-1]) v = v - (64'sd1 << W);
        for (int k = W - 1; k >= 0; k--) begin
            lim = 64'sd1 << (W - 1 - k);
            if (v >= -lim && v < lim) return k;
        end
        return 0;
    endfunction

    task automatic model_block();
        int e;
        bit nz;
        e  = W - 1;
        nz = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cur_in[i] != '0) begin
                nz = 1'b1;
                if (ref_h(cur_in[i]) < e) e = ref_h(cur_in[i]);
            end
        end
        if (!nz) e = 0;
        exp_e = e;
        for (int i = 0; i < N; i++) exp_blk[i] = W'(longint'(cur_in[i]) << e);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_exp", 64'(out_exp), 64'd0);
    endtask

    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = cur_in[i];
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("fill_timeout", 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drains up to 'take' samples while driving random junk on the input side.
    task automatic recv_block(input int stall_pct, input int take);
        int           got;
        int           cycles;
        int           first;
        logic         prev_stall;
        logic [W-1:0] pd;
        logic         pl;
        logic [EW-1:0] pe;
        got = 0; cycles = 0; first = -1; prev_stall = 1'b0;
        pd = '0; pl = 1'b0; pe = '0;
        while (got < take && cycles < 200) begin
            @(negedge clk);
            cycles++;
            in_valid = 1'b1;
            in_data  = W'($urandom);
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(pd));
                check("hold_last", 64'(out_last), 64'(pl));
                check("hold_exp", 64'(out_exp), 64'(pe));
            end
            if (out_valid && first < 0) begin
                first = cycles;
                check("first_latency", 64'(first), 64'd1);
            end
            check("drain_in_ready", 64'(in_ready), 64'd0);
            check("drain_busy", 64'(busy), 64'd1);
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_valid && out_ready) begin
                check("out_data", 64'(out_data), 64'(exp_blk[got]));
                check("out_exp", 64'(out_exp), 64'(exp_e));
                check("out_last", 64'(out_last), 64'(got == N - 1));
                got++;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pl = out_last; pe = out_exp;
        end
        in_valid = 1'b0;
        if (got < take) check("drain_timeout", 64'(got), 64'(take));
        if (take == N) begin
            if (stall_pct == 0) check("no_bubble", 64'(cycles), 64'(N));
            @(negedge clk);
            out_ready = 1'b0;
            check("post_out_valid", 64'(out_valid), 64'd0);
            check("post_in_ready", 64'(in_ready), 64'd1);
            check("post_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic check_entry();
        check("entry_out_valid", 64'(out_valid), 64'd0);
        check("entry_busy", 64'(busy), 64'd1);
        check("entry_in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0].name = "mixed";
        vecs[0].din  = {24'h000000, 24'hFFFF00, 24'h000040, 24'h000100};
        vecs[0].dout = {24'h000000, 24'hC00000, 24'h100000, 24'h400000};
        vecs[0].e    = 14;
        vecs[1].name = "all_zero";
        vecs[1].din  = '0;
        vecs[1].dout = '0;
        vecs[1].e    = 0;
        vecs[2].name = "full_scale";
        vecs[2].din  = {24'h000010, 24'hFFFFFE, 24'h000003, 24'h7FFFFF};
        vecs[2].dout = {24'h000010, 24'hFFFFFE, 24'h000003, 24'h7FFFFF};
        vecs[2].e    = 0;
        vecs[3].name = "all_minus_one";
        vecs[3].din  = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3].dout = {24'h800000, 24'h800000, 24'h800000, 24'h800000};
        vecs[3].e    = 23;

        do_reset();

        // Directed vectors: the first drains with no stalls, the rest with stalls.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N; i++) begin
                cur_in[i]  = vecs[v].din[i];
                exp_blk[i] = vecs[v].dout[i];
            end
            exp_e = vecs[v].e;
            send_samples(N);
            check_entry();
            recv_block((v == 0) ? 0 : 40, N);
        end

        // Reset after two full-scale inputs must not affect the next block.
        for (int i = 0; i < N; i++) cur_in[i] = 24'h7FFFFF;
        send_samples(2);
        do_reset();
        cur_in[0] = 24'h000010; cur_in[1] = 24'h000020;
        cur_in[2] = 24'hFFFFF0; cur_in[3] = 24'h000001;
        model_block();
        check("ref_exp_after_fill_reset", 64'(exp_e), 64'd17);
        send_samples(N);
        check_entry();
        recv_block(30, N);

        // Reset in the middle of a drain.
        cur_in[0] = 24'h7FFFFF; cur_in[1] = 24'h000001;
        cur_in[2] = 24'h000002; cur_in[3] = 24'h000003;
        model_block();
        send_samples(N);
        check_entry();
        recv_block(0, 2);
        do_reset();
        cur_in[0] = 24'h000800; cur_in[1] = 24'hFFF800;
        cur_in[2] = 24'h000000; cur_in[3] = 24'h000001;
        model_block();
        send_samples(N);
        check_entry();
        recv_block(25, N);

        // Random blocks with random back-pressure.
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < N; i++) begin
                logic signed [W-1:0] r;
                r = W'($urandom);
                r = r >>> $urandom_range(W - 1, 0);
                if ($urandom_range(4) == 0) r = '0;
                cur_in[i] = r;
            end
            model_block();
            send_samples(N);
            check_entry();
            recv_block($urandom_range(60), N);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
